sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
- REQ-001 Parameter STEP_W, default 16, width of all step-valued fields and the step output.
- REQ-002 Parameter DWELL_W, default 16, width of the dwell count.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 reset_n  input  1  asynchronous, active-low reset.
- REQ-005 cmd_valid  input  1  sweep command offered.
- REQ-006 cmd_ready  output  1  controller can accept a command.
- REQ-007 cmd_start  input  STEP_W  first step value.
- REQ-008 cmd_end  input  STEP_W  final step value.
- REQ-009 cmd_inc  input  STEP_W  step increment magnitude.
- REQ-010 cmd_dwell  input  DWELL_W  extra cycles held per step value.
- REQ-011 cmd_loop  input  1  bounce request; honoured only per REQ-030.
- REQ-012 abort  input  1  stop the sweep.
- REQ-013 step  output  STEP_W  phase increment driven to the oscillator.
- REQ-014 osc_reset  output  1  one-cycle pulse that clears the oscillator phase.
- REQ-015 busy  output  1  high in RUN.
- REQ-016 done  output  1  one-cycle completion pulse.

Function
- REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE; cmd_ready = (state==IDLE), combinational from state only.
- REQ-018 A command SHALL be accepted on the edge where cmd_valid&&cmd_ready&&!abort; all cmd_* fields are latched at that edge.
- REQ-019 In the cycle after acceptance: state=RUN, step=cmd_start, osc_reset=1 for exactly that one cycle, dwell counter=cmd_dwell.
- REQ-020 Direction SHALL be up if cmd_start<=cmd_end, otherwise down; it is fixed per command except per REQ-030.
- REQ-021 Each step value SHALL be held for cmd_dwell+1 cycles; when the dwell counter is 0, the counter reloads and step advances by inc.
- REQ-022 An increment of 0 SHALL be treated as 1.
- REQ-023 Advance arithmetic SHALL be STEP_W+1 bits and clamp to cmd_end; there is no wrap past 0 or 2^STEP_W-1.
- REQ-024 When the dwell expires with step==cmd_end, the next state is DONE; start==end yields one dwell period, then DONE.
- REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE; step keeps its last value in IDLE.
- REQ-026 abort SHALL force IDLE on the next edge from any state, with no done pulse and step held. In IDLE, abort blocks acceptance.
- REQ-027 cmd_valid while busy SHALL be ignored; there is no queueing.

Reset
- REQ-028 When reset_n=0, the block SHALL asynchronously set state=IDLE, step=0, osc_reset=0, busy=0, done=0 and dwell counter=0.
- REQ-029 After reset release, cmd_ready=1. Reset in mid-sweep SHALL discard the command; no done pulse follows.

Configuration
- REQ-030 With SWEEP_LOOP_EN defined: if cmd_loop=1, reaching an endpoint reverses direction between cmd_start and cmd_end indefinitely, with no DONE and no further osc_reset; only abort or reset ends the sweep. Without SWEEP_LOOP_EN: cmd_loop is ignored and the loop logic is not built.

Structure
- REQ-031 Package sweep_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default STEP_W/DWELL_W constants.
- REQ-032 Sub-module dwell_counter (load, decrement, zero flag) SHALL be instantiated once; the FSM and step arithmetic stay in sweep_ctrl.

Verification
- REQ-033 Up sweep: start=100, end=400, inc=100, dwell=2 -> step 100,200,300,400, each for 3 cycles; osc_reset on the first cycle; done once; busy for 12 cycles.
- REQ-034 Down sweep with clamp: start=1000, end=10, inc=300, dwell=0 -> step 1000,700,400,100,10, then done.
- REQ-035 Edges: inc=0, start=5, end=7 -> 5,6,7. Also start=end=0xFFFF, inc=0xFFFF -> a single step 0xFFFF with no overflow.
- REQ-036 abort on cycle 4 of REQ-033 -> IDLE next cycle, step=200 held, done never asserts; a concurrent cmd_valid in IDLE with abort=1 is not accepted.
- REQ-037 reset_n pulled low mid-sweep -> all outputs 0 immediately, with no clock required; cmd_ready=1 after release.
- REQ-038 SWEEP_LOOP_EN with cmd_loop=1, start=0, end=2, inc=1, dwell=0 -> 0,1,2,1,0,1,... with no done until abort.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the sweep controller.
package sweep_pkg;

    // Default width of step-valued fields and the step output.
    localparam int STEP_W_DEF  = 16;
    // Default width of the dwell count.
    localparam int DWELL_W_DEF = 16;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: loadable down-counter with a zero flag.
// The count saturates at zero; load takes priority over decrement.
module dwell_counter
    import sweep_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next count: reload, count down toward zero, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep controller: steps an oscillator phase increment from a start value
// to an end value, holding each value for a programmable dwell.
// Optional feature macro: SWEEP_LOOP_EN (endless bounce between endpoints
// when the command requests it).
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int STEP_W  = STEP_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [STEP_W-1:0]  cmd_start,
    input  logic [STEP_W-1:0]  cmd_end,
    input  logic [STEP_W-1:0]  cmd_inc,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_loop,
    input  logic               abort,
    output logic [STEP_W-1:0]  step,
    output logic               osc_reset,
    output logic               busy,
    output logic               done
);

    localparam logic [STEP_W-1:0]  STEP_ZERO  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0]  STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

    state_e             state_q,  state_d;
    logic [STEP_W-1:0]  step_q,   step_d;
    logic [STEP_W-1:0]  end_q,    end_d;
    logic [STEP_W-1:0]  inc_q,    inc_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic               dir_up_q, dir_up_d;
    logic               osc_reset_q, osc_reset_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               cnt_load_s;
    logic               cnt_dec_s;
    logic [DWELL_W-1:0] cnt_val_s;
    logic               cnt_zero_s;
    logic [STEP_W-1:0]  tgt_s;

`ifdef SWEEP_LOOP_EN
    logic [STEP_W-1:0]  start_q, start_d;
    logic [STEP_W-1:0]  tgt_q,   tgt_d;
    logic               loop_q,  loop_d;

    assign tgt_s = tgt_q;
`else
    logic               unused_loop_s;

    assign unused_loop_s = cmd_loop;
    assign tgt_s         = end_q;
`endif

    // Move one increment toward tgt in STEP_W+1 bits, clamping at tgt.
    function automatic logic [STEP_W-1:0] advance(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] inc,
        input logic              up,
        input logic [STEP_W-1:0] tgt
    );
        logic [STEP_W:0]   sum;
        logic [STEP_W:0]   diff;
        logic [STEP_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        if (up) begin
            if (sum >= {1'b0, tgt}) res = tgt;
            else                    res = sum[STEP_W-1:0];
        end else begin
            if (diff[STEP_W] || (diff[STEP_W-1:0] <= tgt)) res = tgt;
            else                                           res = diff[STEP_W-1:0];
        end
        return res;
    endfunction

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state, command capture and step arithmetic.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        end_d       = end_q;
        inc_d       = inc_q;
        dwell_d     = dwell_q;
        dir_up_d    = dir_up_q;
        osc_reset_d = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_val_s   = dwell_q;
`ifdef SWEEP_LOOP_EN
        start_d     = start_q;
        tgt_d       = tgt_q;
        loop_d      = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && !abort) begin
                    state_d     = RUN;
                    step_d      = cmd_start;
                    end_d       = cmd_end;
                    inc_d       = (cmd_inc == STEP_ZERO) ? STEP_ONE : cmd_inc;
                    dwell_d     = cmd_dwell;
                    dir_up_d    = (cmd_start <= cmd_end);
                    osc_reset_d = 1'b1;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = cmd_dwell;
`ifdef SWEEP_LOOP_EN
                    start_d     = cmd_start;
                    tgt_d       = cmd_end;
                    loop_d      = cmd_loop;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero_s) begin
                    if (step_q == tgt_s) begin
`ifdef SWEEP_LOOP_EN
                        if (loop_q) begin
                            // Bounce: head back toward the opposite endpoint.
                            dir_up_d   = !dir_up_q;
                            tgt_d      = (tgt_q == end_q) ? start_q : end_q;
                            step_d     = advance(step_q, inc_q, !dir_up_q, tgt_d);
                            cnt_load_s = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        step_d     = advance(step_q, inc_q, dir_up_q, tgt_s);
                        cnt_load_s = 1'b1;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= STEP_ZERO;
            end_q       <= STEP_ZERO;
            inc_q       <= STEP_ZERO;
            dwell_q     <= DWELL_ZERO;
            dir_up_q    <= 1'b0;
            osc_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SWEEP_LOOP_EN
            start_q     <= STEP_ZERO;
            tgt_q       <= STEP_ZERO;
            loop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            end_q       <= end_d;
            inc_q       <= inc_d;
            dwell_q     <= dwell_d;
            dir_up_q    <= dir_up_d;
            osc_reset_q <= osc_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SWEEP_LOOP_EN
            start_q     <= start_d;
            tgt_q       <= tgt_d;
            loop_q      <= loop_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign step      = step_q;
    assign osc_reset = osc_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: each command pushes its hand-computed
// per-cycle output trace; a monitor pops and compares every busy/done cycle.
module tb_sweep_ctrl;

    typedef struct packed {
        logic [15:0] step;
        logic        osc;
        logic        busy;
        logic        done;
        logic [7:0]  id;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start;
    logic [15:0] cmd_end;
    logic [15:0] cmd_inc;
    logic [15:0] cmd_dwell;
    logic        cmd_loop;
    logic        abort;
    logic [15:0] step;
    logic        osc_reset;
    logic        busy;
    logic        done;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  cur_id = 8'd0;

    sweep_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_inc   (cmd_inc),
        .cmd_dwell (cmd_dwell),
        .cmd_loop  (cmd_loop),
        .abort     (abort),
        .step      (step),
        .osc_reset (osc_reset),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // One step value held for dwell+1 cycles; osc_reset only on the first.
    task automatic push_step(input logic [15:0] v, input int dwell, input logic first);
        exp_t e;
        for (int i = 0; i <= dwell; i++) begin
            e.step = v;
            e.osc  = first && (i == 0);
            e.busy = 1'b1;
            e.done = 1'b0;
            e.id   = cur_id;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input logic [15:0] v);
        exp_t e;
        e.step = v;
        e.osc  = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b1;
        e.id   = cur_id;
        exp_q.push_back(e);
    endtask

    // Offer a command for one cycle; returns at the first negedge after acceptance.
    task automatic run_cmd(input logic [15:0] s, input logic [15:0] e, input logic [15:0] inc,
                           input logic [15:0] dw, input logic lp);
        @(negedge clk);
        cmd_start = s;
        cmd_end   = e;
        cmd_inc   = inc;
        cmd_dwell = dw;
        cmd_loop  = lp;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the trace to drain and the controller to go idle.
    task automatic wait_idle(input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_complete", {31'd0, ok}, 32'd1);
        exp_q.delete();
    endtask

    // Monitor: every cycle presenting busy or done consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (busy || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output id=%0d got step=%0h osc=%0b busy=%0b done=%0b want nothing",
                         cur_id, step, osc_reset, busy, done);
            end else begin
                e = exp_q.pop_front();
                if (step !== e.step || osc_reset !== e.osc || busy !== e.busy || done !== e.done) begin
                    errors++;
                    $display("FAIL trace id=%0d got step=%0h osc=%0b busy=%0b done=%0b want step=%0h osc=%0b busy=%0b done=%0b",
                             e.id, step, osc_reset, busy, done, e.step, e.osc, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = 16'd0;
        cmd_end   = 16'd0;
        cmd_inc   = 16'd0;
        cmd_dwell = 16'd0;
        cmd_loop  = 1'b0;
        abort     = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_step",  {16'd0, step}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_osc",   {31'd0, osc_reset}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Up sweep, dwell 2: 100..400, 12 busy cycles, one done.
        cur_id = 8'd1;
        push_step(16'd100, 2, 1'b1);
        push_step(16'd200, 2, 1'b0);
        push_step(16'd300, 2, 1'b0);
        push_step(16'd400, 2, 1'b0);
        push_done(16'd400);
        run_cmd(16'd100, 16'd400, 16'd100, 16'd2, 1'b0);
        wait_idle(100);
        chk("up_step_held", {16'd0, step}, 32'd400);

        // Down sweep with clamp at the end value; a mid-sweep command is ignored.
        cur_id = 8'd2;
        push_step(16'd1000, 0, 1'b1);
        push_step(16'd700, 0, 1'b0);
        push_step(16'd400, 0, 1'b0);
        push_step(16'd100, 0, 1'b0);
        push_step(16'd10, 0, 1'b0);
        push_done(16'd10);
        run_cmd(16'd1000, 16'd10, 16'd300, 16'd0, 1'b0);
        cmd_start = 16'd3;
        cmd_end   = 16'd9;
        cmd_valid = 1'b1;
        chk("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(100);

        // Zero increment behaves as one.
        cur_id = 8'd3;
        push_step(16'd5, 0, 1'b1);
        push_step(16'd6, 0, 1'b0);
        push_step(16'd7, 0, 1'b0);
        push_done(16'd7);
        run_cmd(16'd5, 16'd7, 16'd0, 16'd0, 1'b0);
        wait_idle(100);

        // start == end at the top of the range: one dwell period, no overflow.
        cur_id = 8'd4;
        push_step(16'hFFFF, 1, 1'b1);
        push_done(16'hFFFF);
        run_cmd(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 1'b0);
        wait_idle(100);

        // Sum past 2^16-1 clamps to the end value.
        cur_id = 8'd5;
        push_step(16'hFFF0, 0, 1'b1);
        push_step(16'hFFFF, 0, 1'b0);
        push_done(16'hFFFF);
        run_cmd(16'hFFF0, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
        wait_idle(100);

        // Abort on cycle 4 of the up sweep; concurrent request while aborting is refused.
        cur_id = 8'd6;
        push_step(16'd100, 2, 1'b1);
        push_step(16'd200, 0, 1'b0);
        run_cmd(16'd100, 16'd400, 16'd100, 16'd2, 1'b0);
        repeat (3) @(negedge clk);
        abort     = 1'b1;
        cmd_start = 16'd777;
        cmd_end   = 16'd800;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_step",  {16'd0, step}, 32'd200);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("abort_no_accept", {31'd0, busy}, 32'd0);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_step_held", {16'd0, step}, 32'd200);
        wait_idle(20);

        // Asynchronous reset mid-sweep.
        cur_id = 8'd7;
        push_step(16'd100, 2, 1'b1);
        push_step(16'd200, 2, 1'b0);
        push_step(16'd300, 2, 1'b0);
        push_step(16'd400, 2, 1'b0);
        push_done(16'd400);
        run_cmd(16'd100, 16'd400, 16'd100, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_step",  {16'd0, step}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_osc",   {31'd0, osc_reset}, 32'd0);
        chk("mid_rst_done",  {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        wait_idle(20);

        // Loop request: bounces when built with the loop feature, else ignored.
        cur_id = 8'd8;
`ifdef SWEEP_LOOP_EN
        push_step(16'd0, 0, 1'b1);
        push_step(16'd1, 0, 1'b0);
        push_step(16'd2, 0, 1'b0);
        push_step(16'd1, 0, 1'b0);
        push_step(16'd0, 0, 1'b0);
        push_step(16'd1, 0, 1'b0);
        push_step(16'd2, 0, 1'b0);
        push_step(16'd1, 0, 1'b0);
        run_cmd(16'd0, 16'd2, 16'd1, 16'd0, 1'b1);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("loop_abort_busy", {31'd0, busy}, 32'd0);
        chk("loop_abort_step", {16'd0, step}, 32'd1);
`else
        push_step(16'd0, 0, 1'b1);
        push_step(16'd1, 0, 1'b0);
        push_step(16'd2, 0, 1'b0);
        push_done(16'd2);
        run_cmd(16'd0, 16'd2, 16'd1, 16'd0, 1'b1);
`endif
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
